// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI memory master between the control unit and the debug port.
// Optional WAIT timeout with sticky err flag: define SPI_ARB_TIMEOUT_EN.
module spi_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_ram,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_ram,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              spi_start,
  output logic              spi_we,
  output logic              spi_ram,
  output logic [ADDR_W-1:0] spi_addr,
  output logic [DATA_W-1:0] spi_wdata,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rdata,
  output logic              owner,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              spi_start_q, spi_start_d;
  logic              spi_we_q, spi_we_d;
  logic              spi_ram_q, spi_ram_d;
  logic [ADDR_W-1:0] spi_addr_q, spi_addr_d;
  logic [DATA_W-1:0] spi_wdata_q, spi_wdata_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dbg_done_q, dbg_done_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              owner_q, owner_d;
  logic              last_served_q, last_served_d;
  logic              busy_q, busy_d;
  logic              grant_s, grant_dbg_s, finish_s, timeout_s;
  logic [DATA_W-1:0] resp_data_s;

  // Tie-break: dbg wins only if it is alone or the cpu was served last.
  assign grant_s     = cpu_req | dbg_req;
  assign grant_dbg_s = dbg_req & (~cpu_req | ~last_served_q);
  assign finish_s    = (state_q == S_WAIT) & (spi_done | timeout_s);
  assign resp_data_s = spi_done ? spi_rdata : {DATA_W{1'b1}};

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_s = (state_q == S_WAIT) & ~spi_done & (cnt_q == CNT_W'(TIMEOUT - 1));
  assign err       = err_q;

  // Timeout counter (zero outside WAIT) and sticky error flag.
  always_comb begin
    cnt_d = CNT_W'(0);
    err_d = err_q;
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = CNT_W'(0);
    end
    if (timeout_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Timeout counter and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_W'(0);
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_s;

  assign timeout_s = 1'b0;
  assign err       = 1'b0;
  assign unused_s  = err_clr ^ (TIMEOUT < 32'sd1);
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      spi_start_q   <= 1'b0;
      spi_we_q      <= 1'b0;
      spi_ram_q     <= 1'b0;
      spi_addr_q    <= {ADDR_W{1'b0}};
      spi_wdata_q   <= {DATA_W{1'b0}};
      cpu_done_q    <= 1'b0;
      dbg_done_q    <= 1'b0;
      cpu_rdata_q   <= {DATA_W{1'b0}};
      dbg_rdata_q   <= {DATA_W{1'b0}};
      owner_q       <= 1'b1;
      last_served_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      spi_start_q   <= spi_start_d;
      spi_we_q      <= spi_we_d;
      spi_ram_q     <= spi_ram_d;
      spi_addr_q    <= spi_addr_d;
      spi_wdata_q   <= spi_wdata_d;
      cpu_done_q    <= cpu_done_d;
      dbg_done_q    <= dbg_done_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dbg_rdata_q   <= dbg_rdata_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (finish_s) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; start and done are registered so they land in ISSUE and RESP.
  always_comb begin
    spi_start_d   = 1'b0;
    spi_we_d      = spi_we_q;
    spi_ram_d     = spi_ram_q;
    spi_addr_d    = spi_addr_q;
    spi_wdata_d   = spi_wdata_q;
    cpu_done_d    = 1'b0;
    dbg_done_d    = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    dbg_rdata_d   = dbg_rdata_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    busy_d        = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          spi_start_d = 1'b1;
          owner_d     = grant_dbg_s;
          spi_we_d    = grant_dbg_s ? dbg_we    : cpu_we;
          spi_ram_d   = grant_dbg_s ? dbg_ram   : cpu_ram;
          spi_addr_d  = grant_dbg_s ? dbg_addr  : cpu_addr;
          spi_wdata_d = grant_dbg_s ? dbg_wdata : cpu_wdata;
        end else begin
          spi_start_d = 1'b0;
        end
      end
      S_ISSUE: spi_start_d = 1'b0;
      S_WAIT: begin
        if (finish_s) begin
          cpu_done_d = ~owner_q;
          dbg_done_d = owner_q;
          if (!spi_we_q && !owner_q) begin
            cpu_rdata_d = resp_data_s;
          end else if (!spi_we_q && owner_q) begin
            dbg_rdata_d = resp_data_s;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end else begin
          cpu_done_d = 1'b0;
        end
      end
      S_RESP:  last_served_d = owner_q;
      default: spi_start_d = 1'b0;
    endcase
  end

  assign spi_start = spi_start_q;
  assign spi_we    = spi_we_q;
  assign spi_ram   = spi_ram_q;
  assign spi_addr  = spi_addr_q;
  assign spi_wdata = spi_wdata_q;
  assign cpu_done  = cpu_done_q;
  assign dbg_done  = dbg_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Randomized self-checking bench for spi_mem_arbiter with a transaction-level round-robin model.
// Define SPI_ARB_TIMEOUT_EN to exercise the timeout path (TIMEOUT=8).
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_ram = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_ram = 1'b0;
  logic [15:0] dbg_addr = 16'h0;
  logic [7:0]  dbg_wdata = 8'h0;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rdata = 8'h0;
  logic        err_clr = 1'b0;
  logic        cpu_done, dbg_done, spi_start, spi_we, spi_ram, owner, busy, err;
  logic [7:0]  cpu_rdata, dbg_rdata, spi_wdata;
  logic [15:0] spi_addr;

  spi_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ram(cpu_ram), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_ram(dbg_ram), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .spi_start(spi_start), .spi_we(spi_we), .spi_ram(spi_ram), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_done(spi_done), .spi_rdata(spi_rdata),
    .owner(owner), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: who was served last and what each requester should read back.
  bit         m_last = 1'b1;
  logic [7:0] m_cpu_rd = 8'h0;
  logic [7:0] m_dbg_rd = 8'h0;

  // Requester fields for the next transaction and the master's read value.
  logic        c_we, c_ram, d_we, d_ram;
  logic [15:0] c_addr, d_addr;
  logic [7:0]  c_wd, d_wd, rd_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    c_we = 1'($urandom); c_ram = 1'($urandom); c_addr = 16'($urandom); c_wd = 8'($urandom);
    d_we = 1'($urandom); d_ram = 1'($urandom); d_addr = 16'($urandom); d_wd = 8'($urandom);
    rd_val = 8'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'({cpu_done, dbg_done}), 32'd0);
    check({tag, "_start"}, 32'(spi_start), 32'd0);
  endtask

  // One complete transaction; lat = WAIT cycles before spi_done, stray = spi_done during ISSUE.
  task automatic run_txn(input bit creq, input bit dreq, input int lat, input bit stray);
    bit          win;
    logic        e_we, e_ram;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    win    = (creq && dreq) ? ~m_last : dreq;
    e_we   = win ? d_we : c_we;
    e_ram  = win ? d_ram : c_ram;
    e_addr = win ? d_addr : c_addr;
    e_wd   = win ? d_wd : c_wd;
    cpu_req = creq; cpu_we = c_we; cpu_ram = c_ram; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_req = dreq; dbg_we = d_we; dbg_ram = d_ram; dbg_addr = d_addr; dbg_wdata = d_wd;
    step();
    check("issue_start", 32'(spi_start), 32'd1);
    check("issue_addr", 32'(spi_addr), 32'(e_addr));
    check("issue_we", 32'(spi_we), 32'(e_we));
    check("issue_ram", 32'(spi_ram), 32'(e_ram));
    check("issue_wdata", 32'(spi_wdata), 32'(e_wd));
    check("issue_owner", 32'(owner), 32'(win));
    check("issue_busy", 32'(busy), 32'd1);
    cpu_addr = 16'($urandom); dbg_addr = 16'($urandom);
    cpu_we = 1'($urandom); dbg_we = 1'($urandom);
    spi_done = stray; spi_rdata = 8'($urandom);
    step();
    spi_done = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_done", 32'({cpu_done, dbg_done}), 32'd0);
      check("wait_start", 32'(spi_start), 32'd0);
      step();
    end
    spi_done = 1'b1; spi_rdata = rd_val;
    step();
    spi_done = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    if (!e_we) begin
      if (win) m_dbg_rd = rd_val;
      else     m_cpu_rd = rd_val;
    end
    check("resp_done", 32'({cpu_done, dbg_done}), win ? 32'd1 : 32'd2);
    check("resp_cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
    check("resp_dbg_rdata", 32'(dbg_rdata), 32'(m_dbg_rd));
    check("resp_addr_held", 32'(spi_addr), 32'(e_addr));
    check("resp_start", 32'(spi_start), 32'd0);
    m_last = win;
    step();
    check_idle("post");
    check("post_owner", 32'(owner), 32'(win));
  endtask

  initial begin
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd1);
    check("rst_outs", 32'({cpu_done, dbg_done, spi_start, err, spi_we, spi_ram}), 32'd0);
    check("rst_data", 32'({spi_addr, spi_wdata}), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, dbg_rdata}), 32'd0);
    rst = 1'b0;
    step();
    check_idle("idle");

    // Simultaneous requests from reset: cpu read first, then dbg write.
    rand_fields();
    c_we = 1'b0; c_ram = 1'b0; c_addr = 16'h0001;
    d_we = 1'b1; d_ram = 1'b1; d_addr = 16'h8000; d_wd = 8'h3C;
    run_txn(1'b1, 1'b1, 2, 1'b0);
    run_txn(1'b0, 1'b1, 1, 1'b0);
    check("dbg_rdata_zero", 32'(dbg_rdata), 32'd0);

    // Directed cpu read returning A5 after 5 cycles.
    rand_fields();
    c_we = 1'b0; c_ram = 1'b0; c_addr = 16'h0100; rd_val = 8'hA5;
    run_txn(1'b1, 1'b0, 4, 1'b0);
    check("cpu_rdata_a5", 32'(cpu_rdata), 32'hA5);

    // Fairness with both requests held.
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      run_txn(1'b1, 1'b1, 0, 1'b0);
    end

    // Stray done in IDLE, then early done during ISSUE.
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    check_idle("stray_idle");
    rand_fields();
    run_txn(1'b1, 1'b0, 3, 1'b1);

    // Randomized traffic with idle gaps.
    for (int i = 0; i < 40; i++) begin
      int sel;
      rand_fields();
      sel = int'($urandom_range(2, 0));
      run_txn(sel != 1, sel != 0, int'($urandom_range(5, 0)), 1'($urandom));
      if ($urandom_range(3, 0) == 0) begin
        spi_done = 1'($urandom);
        step();
        spi_done = 1'b0;
        check_idle("gap");
      end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // cpu read with no spi_done: times out after 8 WAIT cycles.
    rand_fields();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_ram = 1'b0; cpu_addr = 16'h1234; dbg_req = 1'b0;
    step();
    cpu_req = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      check("to_wait_done", 32'({cpu_done, dbg_done}), 32'd0);
      check("to_wait_busy", 32'(busy), 32'd1);
      step();
    end
    check("to_done", 32'({cpu_done, dbg_done}), 32'd2);
    check("to_rdata", 32'(cpu_rdata), 32'hFF);
    check("to_err", 32'(err), 32'd1);
    m_cpu_rd = 8'hFF; m_last = 1'b0;
    step();
    check("to_err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to_err_clr", 32'(err), 32'd0);
`else
    // Long wait never aborts; err stays 0 and ignores err_clr.
    rand_fields();
    err_clr = 1'b1;
    run_txn(1'b0, 1'b1, 20, 1'b0);
    err_clr = 1'b0;
    check("no_err", 32'(err), 32'd0);
`endif

    // Reset mid-WAIT aborts the transaction.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4444; dbg_req = 1'b0;
    step();
    cpu_req = 1'b0;
    step();
    step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_last = 1'b1; m_cpu_rd = 8'h0; m_dbg_rd = 8'h0;
    check_idle("rst_wait");
    check("rst_wait_owner", 32'(owner), 32'd1);
    check("rst_wait_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
    spi_done = 1'b1; spi_rdata = 8'h77;
    step();
    spi_done = 1'b0;
    check_idle("rst_late_done");
    step();
    check_idle("rst_late_done2");
    check("rst_late_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));

    // cpu wins the first tie after reset.
    rand_fields();
    run_txn(1'b1, 1'b1, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
